// File: rtl/motor_ctrl_pkg.sv
// Shared types and helpers for the V/f ramp controller.
// Frequencies are in Hz, amplitudes in percent.
package motor_ctrl_pkg;

    localparam int FREQ_W = 14;
    localparam int AMP_W  = 7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RAMP  = 3'd1,
        HOLD  = 3'd2,
        STOP  = 3'd3,
        FAULT = 3'd4
    } ramp_state_t;

    // Move cur toward tgt by step; land exactly on tgt instead of overshooting.
    function automatic logic [FREQ_W-1:0] sat_step(input logic [FREQ_W-1:0] cur,
                                                   input logic [FREQ_W-1:0] tgt,
                                                   input logic [FREQ_W-1:0] step);
        if (cur < tgt)
            return ((tgt - cur) <= step) ? tgt : cur + step;
        else if (cur > tgt)
            return ((cur - tgt) <= step) ? tgt : cur - step;
        return cur;
    endfunction

endpackage

// File: rtl/vf_ramp_ctrl_if.sv
// Command handshake carrying a target frequency and a per-tick step size.
interface vf_ramp_ctrl_if;
    import motor_ctrl_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [FREQ_W-1:0] cmd_freq;
    logic [FREQ_W-1:0] cmd_accel;

    modport master (output cmd_valid, output cmd_freq, output cmd_accel, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_freq, input cmd_accel, output cmd_ready);
endinterface

// File: rtl/ramp_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks, first tick right after reset.
module ramp_tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (cnt == '0)
            cnt <= CW'(DIV - 1);
        else
            cnt <= cnt - CW'(1);
    end

    assign tick = (cnt == '0);
endmodule

// File: rtl/vf_ramp_ctrl.sv
// Slews FREQ toward the commanded target, applies the V/f amplitude law and owns the modulator enable.
// state | meaning
// IDLE  | stopped, FREQ parked at FREQ_MIN, modulator off
// RAMP  | stepping FREQ toward target once per tick
// HOLD  | FREQ equals target, at_speed asserted
// STOP  | controlled decel to FREQ_MIN, then IDLE
// FAULT | e-stop latched, modulator off, commands refused
module vf_ramp_ctrl
    import motor_ctrl_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int RAMP_TICK_HZ = 1000,
    parameter int FREQ_MIN     = 1,
    parameter int FREQ_MAX     = 10000,
    parameter int FREQ_BASE    = 50,
    parameter int AMP_MAX      = 100,
    parameter int AMP_BOOST    = 10
) (
    input  logic              clk,
    input  logic              rst,
    vf_ramp_ctrl_if.slave     cmd,
    input  logic              run,
    input  logic              estop,
    input  logic              clear_fault,
    output logic [FREQ_W-1:0] FREQ,
    output logic [AMP_W-1:0]  AMPLITUDE,
    output logic              active,
    output logic              at_speed,
    output logic              fault
);
    localparam int                DIV      = CLK_HZ / RAMP_TICK_HZ;
    localparam int                AMP_SPAN = AMP_MAX - AMP_BOOST;
    localparam logic [FREQ_W-1:0] F_MIN    = FREQ_W'(FREQ_MIN);
    localparam logic [FREQ_W-1:0] F_MAX    = FREQ_W'(FREQ_MAX);

    ramp_state_t       state;
    logic [FREQ_W-1:0] target;
    logic [FREQ_W-1:0] rate;
    logic              cmd_ready_q;
    logic              tick;
    logic              cmd_acc;
    logic [FREQ_W-1:0] cmd_tgt;
    logic [FREQ_W-1:0] cmd_rate;

    // Span * freq fits in 21 bits for any legal parameter set.
    function automatic logic [AMP_W-1:0] amp_law(input logic [FREQ_W-1:0] f);
        logic [20:0] prod;
        logic [20:0] quo;
        logic [21:0] sum;
        prod = 21'(AMP_SPAN) * 21'(f);
        quo  = prod / 21'(FREQ_BASE);
        sum  = 22'(quo) + 22'(AMP_BOOST);
        return (sum > 22'(AMP_MAX)) ? AMP_W'(AMP_MAX) : AMP_W'(sum);
    endfunction

    ramp_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign cmd.cmd_ready = cmd_ready_q;
    assign cmd_acc       = cmd.cmd_valid && cmd_ready_q;

    always_comb begin
        cmd_tgt  = cmd.cmd_freq;
        if (cmd.cmd_freq < F_MIN)
            cmd_tgt = F_MIN;
        else if (cmd.cmd_freq > F_MAX)
            cmd_tgt = F_MAX;
        cmd_rate = (cmd.cmd_accel == '0) ? FREQ_W'(1) : cmd.cmd_accel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            FREQ        <= F_MIN;
            AMPLITUDE   <= '0;
            active      <= 1'b0;
            at_speed    <= 1'b0;
            fault       <= 1'b0;
            cmd_ready_q <= 1'b0;
            target      <= F_MIN;
            rate        <= FREQ_W'(1);
        end else begin
            // Amplitude tracks the registered FREQ; branches that leave the modulator off force it to 0.
            AMPLITUDE   <= amp_law(FREQ);
            cmd_ready_q <= 1'b1;
            if (cmd_acc) begin
                target <= cmd_tgt;
                rate   <= cmd_rate;
            end
            if (estop) begin
                state       <= FAULT;
                FREQ        <= F_MIN;
                AMPLITUDE   <= '0;
                active      <= 1'b0;
                at_speed    <= 1'b0;
                fault       <= 1'b1;
                cmd_ready_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        FREQ <= F_MIN;
                        if (run) begin
                            state  <= RAMP;
                            active <= 1'b1;
                        end else begin
                            AMPLITUDE <= '0;
                        end
                    end
                    RAMP: begin
                        if (!run)
                            state <= STOP;
                        else if (FREQ == target) begin
                            state    <= HOLD;
                            at_speed <= 1'b1;
                        end else if (tick)
                            FREQ <= sat_step(FREQ, target, rate);
                    end
                    HOLD: begin
                        if (!run) begin
                            state    <= STOP;
                            at_speed <= 1'b0;
                        end else if (cmd_acc ? (cmd_tgt != FREQ) : (target != FREQ)) begin
                            state    <= RAMP;
                            at_speed <= 1'b0;
                        end
                    end
                    STOP: begin
                        if (run)
                            state <= RAMP;
                        else if (FREQ == F_MIN) begin
                            state     <= IDLE;
                            active    <= 1'b0;
                            AMPLITUDE <= '0;
                        end else if (tick)
                            FREQ <= sat_step(FREQ, F_MIN, rate);
                    end
                    FAULT: begin
                        AMPLITUDE   <= '0;
                        cmd_ready_q <= 1'b0;
                        if (clear_fault) begin
                            state       <= IDLE;
                            fault       <= 1'b0;
                            cmd_ready_q <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vf_ramp_ctrl.sv
// Directed bench for vf_ramp_ctrl: tick every 10 cycles, V/f line 10% at 0 Hz to 100% at 50 Hz.
module tb_vf_ramp_ctrl;

    logic        clk;
    logic        rst;
    logic        run;
    logic        estop;
    logic        clear_fault;
    logic [13:0] FREQ;
    logic [6:0]  AMPLITUDE;
    logic        active;
    logic        at_speed;
    logic        fault;

    int n_checks;
    int n_fail;

    vf_ramp_ctrl_if cmd_if ();

    vf_ramp_ctrl #(
        .CLK_HZ       (1000),
        .RAMP_TICK_HZ (100),
        .FREQ_MIN     (1),
        .FREQ_MAX     (10000),
        .FREQ_BASE    (50),
        .AMP_MAX      (100),
        .AMP_BOOST    (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cmd_if),
        .run         (run),
        .estop       (estop),
        .clear_fault (clear_fault),
        .FREQ        (FREQ),
        .AMPLITUDE   (AMPLITUDE),
        .active      (active),
        .at_speed    (at_speed),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_cmd(input int f, input int a);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_freq  = 14'(f);
        cmd_if.cmd_accel = 14'(a);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    // Returns the next FREQ value and cycles waited; gives up after 30 cycles.
    task automatic wait_change(output logic [13:0] v, output int dt);
        logic [13:0] prev;
        prev = FREQ;
        dt = 0;
        do begin
            @(negedge clk);
            dt++;
        end while (FREQ == prev && dt < 30);
        v = FREQ;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(3);
        n_checks++;
        if ({cmd_if.cmd_ready, FREQ, AMPLITUDE, active, at_speed, fault} !== {1'b0, 14'd1, 7'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_hold: got rdy=%b f=%0d a=%0d act=%b spd=%b flt=%b want 0/1/0/0/0/0",
                     cmd_if.cmd_ready, FREQ, AMPLITUDE, active, at_speed, fault);
        end
        rst = 1'b0;
        cyc(1);
        n_checks++;
        if ({cmd_if.cmd_ready, FREQ, AMPLITUDE, active, at_speed, fault} !== {1'b1, 14'd1, 7'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b f=%0d a=%0d act=%b spd=%b flt=%b want 1/1/0/0/0/0",
                     cmd_if.cmd_ready, FREQ, AMPLITUDE, active, at_speed, fault);
        end
    endtask

    task automatic test_ramp_up();
        int          exp_f[5];
        logic [13:0] v;
        int          dt;
        exp_f = '{6, 11, 16, 21, 25};
        send_cmd(25, 5);
        run = 1'b1;
        cyc(1);
        n_checks++;
        if ({active, FREQ, AMPLITUDE} !== {1'b1, 14'd1, 7'd11}) begin
            n_fail++;
            $display("FAIL ramp_start: got act=%b f=%0d a=%0d want 1/1/11", active, FREQ, AMPLITUDE);
        end
        for (int i = 0; i < 5; i++) begin
            wait_change(v, dt);
            n_checks++;
            if (v !== 14'(exp_f[i])) begin
                n_fail++;
                $display("FAIL ramp_up_step%0d: got %0d want %0d", i, v, exp_f[i]);
            end
            if (i > 0) begin
                n_checks++;
                if (dt != 10) begin
                    n_fail++;
                    $display("FAIL ramp_up_spacing%0d: got %0d cycles want 10", i, dt);
                end
            end
        end
        cyc(1);
        n_checks++;
        if ({at_speed, AMPLITUDE} !== {1'b1, 7'd55}) begin
            n_fail++;
            $display("FAIL ramp_up_hold: got spd=%b a=%0d want 1/55", at_speed, AMPLITUDE);
        end
    endtask

    task automatic test_retarget();
        int          exp_f[3];
        logic [13:0] v;
        int          dt;
        exp_f = '{20, 15, 10};
        send_cmd(10, 5);
        n_checks++;
        if (at_speed !== 1'b0) begin
            n_fail++;
            $display("FAIL retarget_leave_hold: got spd=%b want 0", at_speed);
        end
        for (int i = 0; i < 3; i++) begin
            wait_change(v, dt);
            n_checks++;
            if (v !== 14'(exp_f[i])) begin
                n_fail++;
                $display("FAIL retarget_step%0d: got %0d want %0d", i, v, exp_f[i]);
            end
        end
        cyc(1);
        n_checks++;
        if ({at_speed, FREQ, AMPLITUDE} !== {1'b1, 14'd10, 7'd28}) begin
            n_fail++;
            $display("FAIL retarget_hold: got spd=%b f=%0d a=%0d want 1/10/28", at_speed, FREQ, AMPLITUDE);
        end
    endtask

    task automatic test_stop();
        int          exp_up[2];
        int          exp_dn[3];
        logic [13:0] v;
        int          dt;
        exp_up = '{20, 25};
        exp_dn = '{15, 5, 1};
        send_cmd(25, 10);
        for (int i = 0; i < 2; i++) begin
            wait_change(v, dt);
            n_checks++;
            if (v !== 14'(exp_up[i])) begin
                n_fail++;
                $display("FAIL stop_preramp%0d: got %0d want %0d", i, v, exp_up[i]);
            end
        end
        cyc(1);
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_change(v, dt);
            n_checks++;
            if (v !== 14'(exp_dn[i])) begin
                n_fail++;
                $display("FAIL stop_step%0d: got %0d want %0d", i, v, exp_dn[i]);
            end
        end
        n_checks++;
        if ({active, at_speed} !== 2'b10) begin
            n_fail++;
            $display("FAIL stop_reach_min: got act=%b spd=%b want 1/0", active, at_speed);
        end
        cyc(1);
        n_checks++;
        if ({active, AMPLITUDE} !== {1'b0, 7'd0}) begin
            n_fail++;
            $display("FAIL stop_active_fall: got act=%b a=%0d want 0/0", active, AMPLITUDE);
        end
        cyc(15);
        n_checks++;
        if ({active, FREQ, AMPLITUDE} !== {1'b0, 14'd1, 7'd0}) begin
            n_fail++;
            $display("FAIL stop_idle: got act=%b f=%0d a=%0d want 0/1/0", active, FREQ, AMPLITUDE);
        end
    endtask

    task automatic test_min_clamp();
        send_cmd(0, 3);
        run = 1'b1;
        cyc(1);
        n_checks++;
        if (active !== 1'b1) begin
            n_fail++;
            $display("FAIL minclamp_active: got %b want 1", active);
        end
        cyc(1);
        n_checks++;
        if ({at_speed, FREQ, AMPLITUDE} !== {1'b1, 14'd1, 7'd11}) begin
            n_fail++;
            $display("FAIL minclamp_hold: got spd=%b f=%0d a=%0d want 1/1/11", at_speed, FREQ, AMPLITUDE);
        end
        cyc(12);
        n_checks++;
        if ({at_speed, FREQ} !== {1'b1, 14'd1}) begin
            n_fail++;
            $display("FAIL minclamp_stay: got spd=%b f=%0d want 1/1", at_speed, FREQ);
        end
    endtask

    task automatic test_estop();
        logic [13:0] v;
        int          dt;
        send_cmd(30, 2);
        wait_change(v, dt);
        n_checks++;
        if (v !== 14'd3) begin
            n_fail++;
            $display("FAIL estop_preramp: got %0d want 3", v);
        end
        // Next edge after 9 more cycles is a tick edge.
        cyc(9);
        estop            = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_freq  = 14'd40;
        cmd_if.cmd_accel = 14'd4;
        cyc(1);
        cmd_if.cmd_valid = 1'b0;
        n_checks++;
        if ({active, fault, cmd_if.cmd_ready, FREQ, AMPLITUDE, at_speed} !== {3'b010, 14'd1, 7'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL estop_enter: got act=%b flt=%b rdy=%b f=%0d a=%0d spd=%b want 0/1/0/1/0/0",
                     active, fault, cmd_if.cmd_ready, FREQ, AMPLITUDE, at_speed);
        end
        clear_fault = 1'b1;
        cyc(1);
        clear_fault = 1'b0;
        cyc(1);
        n_checks++;
        if ({fault, cmd_if.cmd_ready, active} !== 3'b100) begin
            n_fail++;
            $display("FAIL estop_clear_ignored: got flt=%b rdy=%b act=%b want 1/0/0", fault, cmd_if.cmd_ready, active);
        end
        estop = 1'b0;
        run   = 1'b0;
        cyc(2);
        n_checks++;
        if (fault !== 1'b1) begin
            n_fail++;
            $display("FAIL estop_latched: got flt=%b want 1", fault);
        end
        clear_fault = 1'b1;
        cyc(1);
        clear_fault = 1'b0;
        n_checks++;
        if ({fault, cmd_if.cmd_ready, active, FREQ} !== {3'b010, 14'd1}) begin
            n_fail++;
            $display("FAIL estop_exit: got flt=%b rdy=%b act=%b f=%0d want 0/1/0/1", fault, cmd_if.cmd_ready, active, FREQ);
        end
        cyc(5);
        n_checks++;
        if ({active, FREQ, AMPLITUDE} !== {1'b0, 14'd1, 7'd0}) begin
            n_fail++;
            $display("FAIL estop_idle: got act=%b f=%0d a=%0d want 0/1/0", active, FREQ, AMPLITUDE);
        end
    endtask

    task automatic test_clamp_saturation();
        int          exp_amp[4];
        logic [13:0] v;
        int          dt;
        exp_amp = '{96, 98, 100, 100};
        send_cmd(16383, 0);
        run = 1'b1;
        cyc(1);
        for (int k = 2; k <= 51; k++) begin
            wait_change(v, dt);
            n_checks++;
            if (v !== 14'(k)) begin
                n_fail++;
                $display("FAIL clamp_rate1_step: got %0d want %0d", v, k);
                break;
            end
            if (k >= 48) begin
                cyc(1);
                n_checks++;
                if (AMPLITUDE !== 7'(exp_amp[k-48])) begin
                    n_fail++;
                    $display("FAIL amp_at_%0d: got %0d want %0d", k, AMPLITUDE, exp_amp[k-48]);
                end
            end
        end
        send_cmd(16383, 9000);
        wait_change(v, dt);
        n_checks++;
        if (v !== 14'd9051) begin
            n_fail++;
            $display("FAIL clamp_big_step: got %0d want 9051", v);
        end
        wait_change(v, dt);
        n_checks++;
        if (v !== 14'd10000) begin
            n_fail++;
            $display("FAIL clamp_max: got %0d want 10000", v);
        end
        cyc(1);
        n_checks++;
        if ({at_speed, AMPLITUDE} !== {1'b1, 7'd100}) begin
            n_fail++;
            $display("FAIL clamp_hold: got spd=%b a=%0d want 1/100", at_speed, AMPLITUDE);
        end
    endtask

    task automatic test_reset_mid_ramp();
        logic [13:0] v;
        int          dt;
        send_cmd(5000, 100);
        wait_change(v, dt);
        n_checks++;
        if (v !== 14'd9900) begin
            n_fail++;
            $display("FAIL midreset_preramp: got %0d want 9900", v);
        end
        cyc(3);
        rst = 1'b1;
        run = 1'b0;
        cyc(1);
        n_checks++;
        if ({FREQ, AMPLITUDE, active, at_speed, fault, cmd_if.cmd_ready} !== {14'd1, 7'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL midreset_values: got f=%0d a=%0d act=%b spd=%b flt=%b rdy=%b want 1/0/0/0/0/0",
                     FREQ, AMPLITUDE, active, at_speed, fault, cmd_if.cmd_ready);
        end
        rst = 1'b0;
        cyc(2);
        n_checks++;
        if ({cmd_if.cmd_ready, active, FREQ} !== {2'b10, 14'd1}) begin
            n_fail++;
            $display("FAIL midreset_release: got rdy=%b act=%b f=%0d want 1/0/1", cmd_if.cmd_ready, active, FREQ);
        end
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rst              = 1'b1;
        run              = 1'b0;
        estop            = 1'b0;
        clear_fault      = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_freq  = '0;
        cmd_if.cmd_accel = '0;
        @(negedge clk);
        test_reset();
        test_ramp_up();
        test_retarget();
        test_stop();
        test_min_clamp();
        test_estop();
        test_clamp_saturation();
        test_reset_mid_ramp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
